// File: rtl/line_fill_resp.sv
// line_fill_resp: memory-side responder serving I-side fills and D-side fills/writebacks.
// Ports: i_req/i_addr/i_gnt   I-side fill request, address and grant pulse
//        d_req/d_we/d_addr/d_gnt  D-side request (d_we=1 writeback), address and grant pulse
//        wvalid/wdata         writeback beats, one word per valid cycle
//        rsp_valid/rsp_data/rsp_last/rsp_id  refill beats, id 0 = I-side, 1 = D-side
//        wr_ack               pulse once the last writeback beat is absorbed
//        busy                 any state other than IDLE
//        proto_err            sticky: wvalid seen outside a writeback burst
module line_fill_resp #(
  parameter int LINE_WORDS = 4,
  parameter int MEM_LAT = 2,
  parameter int DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_id,
  output logic        wr_ack,
  output logic        busy,
  output logic        proto_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int BW = $clog2(LINE_WORDS);
  localparam int CW = $clog2(MEM_LAT + 1);
  typedef enum logic [2:0] {IDLE, LAT, RD_BURST, WR_BURST, WR_ACK} state_t;
  state_t state;
  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] base, idx;
  logic [BW-1:0] beat;
  logic [CW-1:0] cnt;
  logic [31:0] addr;
  logic rr_last, id, d_win, emit, mem_we, unused;
  always_comb begin
    d_win = d_req && (!i_req || !rr_last);
    addr = d_win ? d_addr : i_addr;
    idx = base | AW'(beat);
    // beat 0 leaves on the final LAT edge so it lands MEM_LAT cycles after the grant;
    // RD_BURST then spans exactly the cycles in which beats are visible
    emit = (state == LAT && cnt == '0) || (state == RD_BURST && !rsp_last);
    mem_we = state == WR_BURST && wvalid;
  end
  assign busy = state != IDLE;
  assign unused = ^{addr[31:AW+2], addr[BW+1:0]};
  always_ff @(posedge clk)
    if (mem_we) mem[idx] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      i_gnt <= 1'b0;
      d_gnt <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_last <= 1'b0;
      rsp_id <= 1'b0;
      wr_ack <= 1'b0;
      proto_err <= 1'b0;
      rr_last <= 1'b1;
      id <= 1'b0;
      base <= '0;
      beat <= '0;
      cnt <= '0;
    end else begin
      i_gnt <= 1'b0;
      d_gnt <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_last <= 1'b0;
      wr_ack <= 1'b0;
      proto_err <= proto_err | (wvalid && state != WR_BURST);
      if (emit) begin
        rsp_valid <= 1'b1;
        rsp_data <= mem[idx];
        rsp_last <= &beat;
        rsp_id <= id;
        beat <= beat + 1'b1;
      end
      case (state)
        IDLE:
          if (i_req || d_req) begin
            i_gnt <= !d_win;
            d_gnt <= d_win;
            rr_last <= d_win;
            id <= d_win;
            base <= {addr[AW+1:BW+2], BW'(0)};
            beat <= '0;
            cnt <= CW'(MEM_LAT - 1);
            state <= (d_win && d_we) ? WR_BURST : LAT;
          end
        LAT: begin
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= RD_BURST;
        end
        RD_BURST:
          if (rsp_last) state <= IDLE;
        WR_BURST:
          if (wvalid) begin
            beat <= beat + 1'b1;
            if (&beat) begin
              wr_ack <= 1'b1;
              state <= WR_ACK;
            end
          end
        WR_ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_line_fill_resp.sv
// tb_line_fill_resp: directed self-checking bench for line_fill_resp (defaults 4 words, latency 2, 4096 words).
module tb_line_fill_resp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, wvalid = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, wdata = '0;
  logic i_gnt, d_gnt, rsp_valid, rsp_last, rsp_id, wr_ack, busy, proto_err;
  logic [31:0] rsp_data;
  int vecs = 0;
  int errs = 0;
  line_fill_resp dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_gnt(d_gnt),
    .wvalid(wvalid), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_id(rsp_id),
    .wr_ack(wr_ack), .busy(busy), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // From the grant cycle: one latency cycle, four beats, then an idle cycle.
  task automatic beats(input logic side, input logic [127:0] e, input logic chkd);
    cyc();
    chk("lat_gap", {31'd0, rsp_valid}, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("beat_ctl", {29'd0, rsp_valid, rsp_last, rsp_id}, {29'd0, 1'b1, k == 3, side});
      if (chkd) chk("beat_data", rsp_data, e[32*k +: 32]);
    end
    cyc();
    chk("burst_end", {30'd0, rsp_valid, busy}, 0);
  endtask
  task automatic rd_line(input logic side, input logic [31:0] a, input logic [127:0] e);
    if (side) begin d_req = 1'b1; d_we = 1'b0; d_addr = a; end
    else begin i_req = 1'b1; i_addr = a; end
    cyc();
    chk("rd_gnt", {30'd0, i_gnt, d_gnt}, side ? 32'd1 : 32'd2);
    i_req = 1'b0;
    d_req = 1'b0;
    beats(side, e, 1'b1);
  endtask
  task automatic wr_line(input logic [31:0] a, input logic [127:0] d, input logic [3:0] bub);
    d_req = 1'b1; d_we = 1'b1; d_addr = a;
    cyc();
    chk("wr_gnt", {30'd0, i_gnt, d_gnt}, 1);
    d_req = 1'b0; d_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wvalid = 1'b1; wdata = d[32*k +: 32];
      cyc();
      if (k < 3) begin
        chk("wr_ack_early", {31'd0, wr_ack}, 0);
        if (bub[k]) begin wvalid = 1'b0; cyc(); end
      end
    end
    wvalid = 1'b0;
    chk("wr_ack", {30'd0, wr_ack, busy}, 3);
    cyc();
    chk("wr_done", {30'd0, wr_ack, busy}, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    cyc();
    cyc();
    chk("reset_ctl", {24'd0, i_gnt, d_gnt, rsp_valid, rsp_last, rsp_id, wr_ack, busy, proto_err}, 0);
    chk("reset_data", rsp_data, 0);
    rst_n = 1'b1;
    cyc();
    // contested read: I wins first, D served on IDLE re-entry
    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    cyc();
    chk("arb_first", {30'd0, i_gnt, d_gnt}, 2);
    i_req = 1'b0;
    beats(1'b0, '0, 1'b0);
    chk("arb_wait", {31'd0, d_gnt}, 0);
    cyc();
    chk("arb_second", {30'd0, i_gnt, d_gnt}, 1);
    d_req = 1'b0;
    beats(1'b1, '0, 1'b0);
    // preload 0x40..0x43, then I-side fill of 0x104
    wr_line(32'h100, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'b0000);
    rd_line(1'b0, 32'h104, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    // writeback with bubbles, then read-after-write on the same line
    wr_line(32'h200, {32'h44, 32'h33, 32'h22, 32'h11}, 4'b0101);
    rd_line(1'b1, 32'h200, {32'h44, 32'h33, 32'h22, 32'h11});
    // stray wvalid in IDLE sets sticky proto_err, memory untouched
    chk("proto_clean", {31'd0, proto_err}, 0);
    wvalid = 1'b1; wdata = 32'hDEAD_BEEF;
    cyc();
    wvalid = 1'b0;
    chk("proto_set", {30'd0, proto_err, busy}, 2);
    rd_line(1'b0, 32'h100, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    chk("proto_sticky", {31'd0, proto_err}, 1);
    // high address bits alias onto word 0
    wr_line(32'h0, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'b0000);
    rd_line(1'b0, 32'h0001_0000, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    chk("proto_sticky2", {31'd0, proto_err}, 1);
    // reset during the second read beat
    i_req = 1'b1; i_addr = 32'h100;
    cyc();
    chk("rst_gnt", {31'd0, i_gnt}, 1);
    i_req = 1'b0;
    cyc();
    cyc();
    chk("rst_beat0", rsp_data, 32'hA0);
    cyc();
    chk("rst_beat1", {30'd0, rsp_valid, rsp_last}, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", {24'd0, i_gnt, d_gnt, rsp_valid, rsp_last, rsp_id, wr_ack, busy, proto_err}, 0);
    chk("async_rst_data", rsp_data, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    rd_line(1'b0, 32'h10C, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
